irq_priority_ctrl: RTL and testbench
====================================

Name: irq_priority_ctrl

Overview:
- Parametrised, registered successor to the 4-to-2 priority encoder.
- Captures N interrupt request lines into a pending register and applies a per-source mask.
- Presents the highest-priority enabled source as a binary ID through a valid/ack handshake, then holds off new presentations until end-of-interrupt (EOI).
- Sits between peripheral request lines and the CPU interrupt interface.

Parameters:
N, 8, number of request sources (2..32)
W, $clog2(N), width of the ID output
EDGE, 1, 1 = rising-edge capture into pending; 0 = level-sensitive (pending follows irq_in)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
irq_in  in  N  raw request lines, synchronous to clk
mask  in  N  per-source enable, 1 = source may be presented
irq_ack  in  1  CPU accepts presented interrupt
eoi  in  1  CPU finished servicing accepted interrupt
irq_valid  out  1  an interrupt ID is being presented
irq_id  out  W  binary index of presented or in-service source
pending  out  N  current pending register
busy  out  1  an interrupt is in service (acked, awaiting eoi)

Behaviour:
- Reset (async assert, sync release): pending=0, irq_in history=0, irq_valid=0, irq_id=0, busy=0, state=IDLE, rotation pointer=N-1.
- EDGE=1 capture:
  - pending[i] sets on the cycle irq_in[i]=1 while its previous sample was 0.
  - Cleared only by ack of ID i.
  - Set and clear on the same bit in the same cycle: set wins, so the new edge is not lost.
- EDGE=0 capture: pending = irq_in registered each cycle; ack does not clear.
- Masking: affects selection only. pending bits still latch while masked.
- Candidate set: pending & mask.
- Selection: highest index wins, matching the 4-to-2 encoder rule; rotating under IRQ_RR_EN.
- FSM IDLE:
  - irq_valid=0.
  - If candidate set is non-zero, next state is PRESENT and irq_id is registered with the winner.
  - Latency: irq_in edge sampled at edge k, pending set at k, irq_valid=1 after edge k+1 (2 cycles).
- FSM PRESENT:
  - irq_valid=1.
  - irq_id frozen even if a higher source arrives or the presented source is masked.
  - irq_ack=1 → ACTIVE; pending[irq_id] cleared (EDGE=1).
- FSM ACTIVE:
  - irq_valid=0, busy=1, irq_id holds the serviced ID.
  - eoi=1 → IDLE; busy=0 next cycle.
  - The next presentation is possible one cycle after returning to IDLE.
- Protocol violations:
  - irq_ack outside PRESENT is ignored.
  - eoi outside ACTIVE is ignored.
  - irq_ack and eoi together in PRESENT: ack taken, eoi ignored.
- No nesting: requests arriving in PRESENT or ACTIVE only accumulate in pending.
- Mid-operation reset: returns immediately to reset values; in-flight interrupt and pending are lost.
- N not a power of two: IDs ≥ N are never produced.

Optional Feature:
- Macro: IRQ_RR_EN.
- Defined:
  - Rotating priority with pointer p (reset N-1).
  - Search order is p, p-1, ..., 0, N-1, ..., p+1.
  - On each ack of ID k, p becomes (k-1) mod N, so the served source drops to lowest priority.
- Undefined: fixed priority, highest index wins; pointer logic not synthesised.

Test Plan:
- N=8, EDGE=1, mask=8'hFF, irq_in rises on bit 5 → irq_valid=1, irq_id=5 two cycles later; ack → pending[5]=0, busy=1; eoi → busy=0.
- irq_in=8'b0010_0110 rising together → irq_id=5; after ack/eoi → 2; then 1 (fixed priority).
- mask=8'b1111_0111, edge on bit 3 → pending[3]=1, irq_valid stays 0; set mask[3]=1 → irq_id=3 presented.
- Present ID 2, then raise bit 7 before ack → irq_id stays 2 until ack; after eoi, 7 is presented.
- Assert rst_n=0 mid-ACTIVE with pending=8'h81 → all outputs 0 and pending=0 immediately, without waiting for a clock edge.
- IRQ_RR_EN, bits 7 and 1 held level (EDGE=0) → presented sequence 7, 1, 7, 1 across successive ack/eoi cycles.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: registered N-source interrupt priority controller.
// Requests are captured into a pending register (edge or level), masked, and the
// winning source is presented as a binary ID through a valid/ack handshake. No new
// presentation happens until the CPU signals end-of-interrupt.
// Optional feature macro: IRQ_RR_EN (rotating priority; fixed highest-index-wins
// when undefined).
module irq_priority_ctrl #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = $clog2(N),
    parameter bit          EDGE = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] irq_in,
    input  logic [N-1:0] mask,
    input  logic         irq_ack,
    input  logic         eoi,
    output logic         irq_valid,
    output logic [W-1:0] irq_id,
    output logic [N-1:0] pending,
    output logic         busy
);

    typedef enum logic [1:0] {StIdle, StPresent, StActive} state_e;

    state_e         state_q;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   irq_prev_q;
    logic [N-1:0]   cand;
    logic [N-1:0]   ack_clr;
    logic           irq_valid_q;
    logic           busy_q;
    logic [W-1:0]   irq_id_q;
    logic [W-1:0]   win;
    logic           found;
    logic           ack_take;

    assign ack_take = (state_q == StPresent) && irq_ack;
    assign cand     = pending_q & mask;

    // Pending next state: new edges set, an accepted ack clears; a same-cycle set wins.
    always_comb begin
        ack_clr = '0;
        if (ack_take) begin
            ack_clr[irq_id_q] = 1'b1;
        end
        if (EDGE) begin
            pending_d = (pending_q & ~ack_clr) | (irq_in & ~irq_prev_q);
        end else begin
            pending_d = irq_in;
        end
    end

    // Request history and pending register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
        end else begin
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
        end
    end

`ifdef IRQ_RR_EN
    logic [W-1:0] ptr_q;
    logic [W-1:0] idx;

    // Rotating search: p, p-1, ..., 0, N-1, ..., p+1; first candidate found wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = W'((32'(ptr_q) + N - i) % N);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Served source drops to lowest priority: pointer moves to (k-1) mod N on ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= W'(N - 1);
        end else if (ack_take) begin
            ptr_q <= (irq_id_q == '0) ? W'(N - 1) : irq_id_q - 1'b1;
        end
    end
`else
    // Fixed priority: the highest set candidate index wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cand[i]) begin
                found = 1'b1;
                win   = W'(i);
            end
        end
    end
`endif

    // Presentation FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (found) begin
                        state_q     <= StPresent;
                        irq_valid_q <= 1'b1;
                        irq_id_q    <= win;
                    end
                end
                StPresent: begin
                    // ID stays frozen here; eoi alongside ack is ignored.
                    if (irq_ack) begin
                        state_q     <= StActive;
                        irq_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                StActive: begin
                    if (eoi) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    irq_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign irq_valid = irq_valid_q;
    assign irq_id    = irq_id_q;
    assign pending   = pending_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: directed bench for irq_priority_ctrl.
// DUT a: N=8, edge capture. DUT b: N=8, level capture (rotation check when IRQ_RR_EN).
// Expected IDs are queued when requests are driven and popped on each presentation.
module tb_irq_priority_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_a, mask_a, irq_b, mask_b;
    logic       ack, eoi;

    logic       valid_a, valid_b, busy_a, busy_b;
    logic [2:0] id_a, id_b;
    logic [7:0] pend_a, pend_b;

    bit         sel = 1'b0;
    logic       valid_s, busy_s;
    logic [2:0] id_s;
    logic [7:0] pend_s;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];

    always #5 clk = ~clk;

    irq_priority_ctrl #(.N(8), .EDGE(1'b1)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_a),
        .mask      (mask_a),
        .irq_ack   (ack),
        .eoi       (eoi),
        .irq_valid (valid_a),
        .irq_id    (id_a),
        .pending   (pend_a),
        .busy      (busy_a)
    );

    irq_priority_ctrl #(.N(8), .EDGE(1'b0)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .irq_in    (irq_b),
        .mask      (mask_b),
        .irq_ack   (ack),
        .eoi       (eoi),
        .irq_valid (valid_b),
        .irq_id    (id_b),
        .pending   (pend_b),
        .busy      (busy_b)
    );

    assign valid_s = sel ? valid_b : valid_a;
    assign busy_s  = sel ? busy_b  : busy_a;
    assign id_s    = sel ? id_b    : id_a;
    assign pend_s  = sel ? pend_b  : pend_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (valid_s !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " valid"}, 32'(valid_s), 32'd1);
    endtask

    // Pop expected ID, compare, then run ack and eoi (optionally eoi together with ack).
    task automatic serve(input string tag, input bit both);
        logic [2:0] e;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 3'bxxx;
        chk({tag, " id"}, 32'(id_s), 32'(e));
        ack = 1'b1;
        eoi = both;
        step(1);
        ack = 1'b0;
        eoi = 1'b0;
        chk({tag, " busy"}, 32'(busy_s), 32'd1);
        chk({tag, " valid_in_active"}, 32'(valid_s), 32'd0);
        chk({tag, " id_held"}, 32'(id_s), 32'(e));
        eoi = 1'b1;
        step(1);
        eoi = 1'b0;
        chk({tag, " busy_clr"}, 32'(busy_s), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        irq_a  = '0;
        irq_b  = '0;
        mask_a = 8'hFF;
        mask_b = 8'hFF;
        ack    = 1'b0;
        eoi    = 1'b0;

        // Reset values
        #12;
        chk("rst valid", 32'(valid_a), 32'd0);
        chk("rst id", 32'(id_a), 32'd0);
        chk("rst pending", 32'(pend_a), 32'd0);
        chk("rst busy", 32'(busy_a), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(1);

        // Single source on bit 5, two-cycle latency
        irq_a = 8'h20;
        exp_q.push_back(3'd5);
        step(1);
        chk("b5 pending", 32'(pend_a), 32'h20);
        chk("b5 not yet valid", 32'(valid_a), 32'd0);
        step(1);
        chk("b5 valid", 32'(valid_a), 32'd1);
        serve("b5", 1'b0);
        chk("b5 pending clr", 32'(pend_a), 32'h00);
        irq_a = 8'h00;
        step(1);

        // Three simultaneous edges served in fixed priority order
        irq_a = 8'b0010_0110;
        exp_q.push_back(3'd5);
        exp_q.push_back(3'd2);
        exp_q.push_back(3'd1);
        for (int i = 0; i < 3; i++) begin
            wait_valid("multi");
            serve("multi", 1'b0);
        end
        chk("multi drained", 32'(pend_a), 32'h00);
        irq_a = 8'h00;
        step(2);

        // Stray ack/eoi while idle are ignored
        ack = 1'b1;
        eoi = 1'b1;
        step(1);
        ack = 1'b0;
        eoi = 1'b0;
        step(1);
        chk("stray busy", 32'(busy_a), 32'd0);
        chk("stray valid", 32'(valid_a), 32'd0);

        // Masked source latches but is not presented until unmasked
        mask_a = 8'b1111_0111;
        irq_a  = 8'h08;
        step(3);
        chk("mask pending", 32'(pend_a), 32'h08);
        chk("mask no valid", 32'(valid_a), 32'd0);
        mask_a = 8'hFF;
        exp_q.push_back(3'd3);
        wait_valid("unmask");
        serve("unmask", 1'b0);
        irq_a = 8'h00;
        step(1);

        // Presented ID frozen when higher source arrives; ack+eoi together takes only ack
        irq_a = 8'h04;
        exp_q.push_back(3'd2);
        wait_valid("freeze");
        irq_a = 8'h84;
        step(2);
        chk("freeze pending", 32'(pend_a), 32'h84);
        chk("freeze still valid", 32'(valid_a), 32'd1);
        chk("freeze id", 32'(id_a), 32'd2);
        exp_q.push_back(3'd7);
        serve("freeze2", 1'b1);
        wait_valid("late7");
        serve("late7", 1'b0);
        irq_a = 8'h00;
        step(1);

        // Asynchronous reset in the middle of ACTIVE with pending = 8'h81
        irq_a = 8'h81;
        exp_q.push_back(3'd7);
        wait_valid("rst7");
        chk("rst7 id", 32'(id_a), 32'(exp_q.pop_front()));
        ack = 1'b1;
        step(1);
        ack   = 1'b0;
        irq_a = 8'h01;
        step(1);
        irq_a = 8'h81;
        step(1);
        chk("pre-rst pending", 32'(pend_a), 32'h81);
        chk("pre-rst busy", 32'(busy_a), 32'd1);
        irq_a = 8'h00;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async pending", 32'(pend_a), 32'h00);
        chk("async busy", 32'(busy_a), 32'd0);
        chk("async valid", 32'(valid_a), 32'd0);
        chk("async id", 32'(id_a), 32'd0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Level capture on DUT b, bits 7 and 1 held
        sel   = 1'b1;
        irq_b = 8'h82;
`ifdef IRQ_RR_EN
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd1);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(3'd7);
`endif
        for (int i = 0; i < 4; i++) begin
            wait_valid("level");
            serve("level", 1'b0);
            chk("level pending kept", 32'(pend_b), 32'h82);
        end
        irq_b = 8'h00;
        step(2);
        chk("level pending follows", 32'(pend_b), 32'h00);
        chk("a idle busy", 32'(busy_a), 32'd0);
        chk("a idle valid", 32'(valid_a), 32'd0);
        chk("queue empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
